// File: rtl/arbiter_pkg.sv
// Shared constants, FSM encoding and one-hot helpers for the packet mux
// that sits behind the 4-way round-robin arbiter.
package arbiter_pkg;

  localparam int NUM_PORTS  = 4;
  localparam int PORT_IDX_W = 2;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Whole FSM register as one struct so checkers can bind to a single signal.
  typedef struct packed {
    logic [0:0]            state;
    logic [PORT_IDX_W-1:0] sel;
  } arb_fsm_t;

  function automatic logic is_onehot(input logic [NUM_PORTS-1:0] v);
    return (v != '0) && ((v & (v - {{(NUM_PORTS-1){1'b0}}, 1'b1})) == '0);
  endfunction

  function automatic logic [PORT_IDX_W-1:0] onehot_to_idx(input logic [NUM_PORTS-1:0] v);
    logic [PORT_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (v[i]) idx = i[PORT_IDX_W-1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/arbiter_pkt_mux_pkt_out_reg.sv
// One-entry valid/ready output register carrying a beat, its last flag and
// the index of the port it came from.
module pkt_out_reg
  import arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_W-1:0]     load_data,
  input  logic                  load_last,
  input  logic [PORT_IDX_W-1:0] load_port,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_last,
  output logic [PORT_IDX_W-1:0] out_port
);

  // A load always wins over a drain, so accept+drain in one cycle keeps valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_port  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_last  <= load_last;
      out_port  <= load_port;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/arbiter_pkt_mux.sv
// Packet-level switch behind the round-robin arbiter: locks the granted port
// until its last beat is accepted. ARB_PKT_MUX_MAXLEN_EN adds a length limit.
module arbiter_pkt_mux
  import arbiter_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          in_valid,
  output logic [NUM_PORTS-1:0]          in_ready,
  input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
  input  logic [NUM_PORTS-1:0]          in_last,
  output logic [NUM_PORTS-1:0]          arb_req,
  input  logic [NUM_PORTS-1:0]          arb_grant,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_last,
  output logic [PORT_IDX_W-1:0]         out_port,
  output logic                          err
);

  localparam logic [0:0] ST_IDLE   = IDLE;
  localparam logic [0:0] ST_LOCKED = LOCKED;

  // Handshakes: a beat moves when valid & ready are both high at the rising
  // edge; valid never waits on ready, ready may depend on valid-free state only.

  arb_fsm_t          fsm;
  logic              stage_free;
  logic              accept;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic              trunc;
  logic              end_pkt;

  assign stage_free = !out_valid || out_ready;
  assign sel_last   = in_last[fsm.sel];
  assign sel_data   = in_data[fsm.sel*DATA_W +: DATA_W];
  assign accept     = (fsm.state == ST_LOCKED) && in_valid[fsm.sel] && stage_free;

  // Requests are withheld while locked so the arbiter's pointer holds.
  always_comb begin
    arb_req  = '0;
    in_ready = '0;
    if (!rst) begin
      if (fsm.state == ST_IDLE) arb_req = in_valid;
      else                      in_ready[fsm.sel] = stage_free;
    end
  end

`ifdef ARB_PKT_MUX_MAXLEN_EN
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  logic [CNT_W-1:0] beat_cnt;
  logic             err_q;

  assign trunc = accept && !sel_last && (beat_cnt == CNT_W'(MAX_BEATS - 1));
  assign err   = err_q;

  // Held at zero while idle, which is the same as clearing on entry to LOCKED.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= trunc;
      if (fsm.state == ST_IDLE) beat_cnt <= '0;
      else if (accept)          beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_cfg;

  assign trunc      = 1'b0;
  assign err        = 1'b0;
  assign unused_cfg = (MAX_BEATS > 0);
`endif

  assign end_pkt = accept && (sel_last || trunc);

  // Zero or multi-hot grants are ignored and the FSM simply stays idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm.state <= ST_IDLE;
      fsm.sel   <= '0;
    end else if (fsm.state == ST_IDLE) begin
      if (is_onehot(arb_grant)) begin
        fsm.sel   <= onehot_to_idx(arb_grant);
        fsm.state <= ST_LOCKED;
      end
    end else if (end_pkt) begin
      fsm.state <= ST_IDLE;
    end
  end

  pkt_out_reg #(
    .DATA_W (DATA_W)
  ) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_data (sel_data),
    .load_last (sel_last || trunc),
    .load_port (fsm.sel),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_port  (out_port)
  );

endmodule

// File: tb/tb_arbiter_pkt_mux.sv
// Bench for arbiter_pkt_mux: behavioural round-robin arbiter, per-port packet
// sources, and a scoreboard holding every beat in per-port send order.
module tb_arbiter_pkt_mux;

  localparam int DATA_W = 32;
`ifdef ARB_PKT_MUX_MAXLEN_EN
  localparam int TB_MAX    = 4;
  localparam bit MAXLEN_ON = 1'b1;
`else
  localparam int TB_MAX    = 16;
  localparam bit MAXLEN_ON = 1'b0;
`endif
  localparam int W = DATA_W + 4;  // {port[1:0], sent_last, expected_last, data}

  logic                clk;
  logic                rst;
  logic [3:0]          in_valid;
  logic [3:0]          in_ready;
  logic [4*DATA_W-1:0] in_data;
  logic [3:0]          in_last;
  logic [3:0]          arb_req;
  logic [3:0]          arb_grant;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_data;
  logic                out_last;
  logic [1:0]          out_port;
  logic                err;

  arbiter_pkt_mux #(
    .DATA_W    (DATA_W),
    .MAX_BEATS (TB_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .arb_req   (arb_req),
    .arb_grant (arb_grant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_port  (out_port),
    .err       (err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- round-robin arbiter model ----------------
  logic [1:0] rr_ptr;

  function automatic logic [3:0] rr_pick(input logic [3:0] req, input logic [1:0] p);
    logic [3:0] g;
    logic [1:0] j;
    g = '0;
    for (int k = 0; k < 4; k++) begin
      j = p + 2'(k);
      if (g == '0 && req[j]) g[j] = 1'b1;
    end
    return g;
  endfunction

  assign arb_grant = rr_pick(arb_req, rr_ptr);

  always @(posedge clk) begin
    if (rst) rr_ptr <= 2'd0;
    else for (int k = 0; k < 4; k++) if (arb_grant[k]) rr_ptr <= 2'(k + 1);
  end

  // ---------------- bench state ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  logic [DATA_W:0] src_mem [4][64];
  int              src_head [4];
  int              src_tail [4];
  int              seq_id   [4];
  int              acc_cnt  [4];
  int              valid_pct, ready_pct;

  logic [W-1:0] exp_q [$];
  int           out_log [$];
  int           exp_err, err_seen;
  int           open_port, in_cnt, out_open;

  logic              prev_ov, prev_or, prev_last, prev_rst;
  logic [DATA_W-1:0] prev_data;
  logic [1:0]        prev_port;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue one packet on port p; expected last follows the length-limit rule when enabled.
  task automatic push_pkt(input int p, input int len);
    logic [DATA_W-1:0] d;
    logic              l, el;
    int                sub;
    sub = 0;
    for (int b = 0; b < len; b++) begin
      d  = {2'(p), 14'(seq_id[p]), 16'($urandom)};
      l  = (b == len - 1);
      sub++;
      el = l || (MAXLEN_ON && sub == TB_MAX);
      if (el) sub = 0;
      src_mem[p][src_tail[p] % 64] = {l, d};
      src_tail[p]++;
      exp_q.push_back({2'(p), l, el, d});
    end
    seq_id[p]++;
  endtask

  task automatic drive();
    for (int p = 0; p < 4; p++) begin
      if (src_tail[p] > src_head[p] && $urandom_range(0, 99) < valid_pct) begin
        in_valid[p] = 1'b1;
        {in_last[p], in_data[p*DATA_W +: DATA_W]} = src_mem[p][src_head[p] % 64];
      end else begin
        in_valid[p] = 1'b0;
        in_last[p]  = 1'b0;
      end
    end
    out_ready = ($urandom_range(0, 99) < ready_pct);
  endtask

  // One clock: sample and check at the falling edge, advance sources after the rising edge.
  task automatic step();
    logic [3:0] fire;
    logic       ofire;
    int         fp, found;
    logic [W-1:0] e;
    @(negedge clk);
    fire  = in_valid & in_ready;
    ofire = out_valid & out_ready;
    if (rst) begin
      check("rst_req", arb_req, 4'b0);
      open_port = -1;
      in_cnt    = 0;
      out_open  = -1;
    end else begin
      check("in_ready_onehot0", $onehot0(in_ready), 1);
      check("req_src", (arb_req == in_valid) || (arb_req == 4'b0), 1);
      if (open_port >= 0) begin
        check("lock_req", arb_req, 4'b0);
        check("lock_ready", in_ready & ~(4'b1 << open_port), 4'b0);
      end
      if (out_valid && !out_ready) check("stall_ready", in_ready, 4'b0);
      if (!prev_rst && prev_ov && !prev_or) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
        check("hold_last", out_last, prev_last);
        check("hold_port", out_port, prev_port);
      end
      if (err) err_seen++;
      if (ofire) begin
        found = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
          if (found < 0 && exp_q[i][W-1:W-2] == out_port) found = i;
        end
        check("sb_found", found >= 0, 1);
        if (found >= 0) begin
          e = exp_q[found];
          check("sb_data", out_data, e[DATA_W-1:0]);
          check("sb_last", out_last, e[DATA_W]);
          if (e[DATA_W] && !e[DATA_W+1]) exp_err++;
          exp_q.delete(found);
        end
        if (out_open >= 0) check("sb_interleave", out_port, out_open);
        out_open = out_last ? -1 : int'(out_port);
        out_log.push_back(int'(out_port));
      end
      fp = -1;
      for (int p = 0; p < 4; p++) if (fire[p] && fp < 0) fp = p;
      if (fp >= 0) begin
        acc_cnt[fp]++;
        in_cnt++;
        if (in_last[fp] || (MAXLEN_ON && in_cnt == TB_MAX)) begin
          open_port = -1;
          in_cnt    = 0;
        end else begin
          open_port = fp;
        end
      end
    end
    prev_ov   = out_valid;
    prev_or   = out_ready;
    prev_data = out_data;
    prev_last = out_last;
    prev_port = out_port;
    prev_rst  = rst;
    @(posedge clk);
    #1;
    if (!rst) for (int p = 0; p < 4; p++) if (fire[p]) src_head[p]++;
    drive();
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || out_valid) && n < limit) begin
      step();
      n++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  int exp_order [4] = '{0, 0, 2, 2};
  int ovq [$];
  int s, r1, g, i, n, a0;

  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0; in_last = '0; out_ready = 1'b0;
    valid_pct = 100; ready_pct = 100;
    open_port = -1; in_cnt = 0; out_open = -1; exp_err = 0; err_seen = 0;
    prev_ov = 0; prev_or = 0; prev_last = 0; prev_data = '0; prev_port = '0; prev_rst = 1;
    for (int p = 0; p < 4; p++) begin
      src_head[p] = 0; src_tail[p] = 0; seq_id[p] = 0; acc_cnt[p] = 0;
    end

    // Reset state with ports 0 and 2 already holding 2-beat packets.
    push_pkt(0, 2);
    push_pkt(2, 2);
    repeat (3) step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_port", out_port, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_arb_req", arb_req, 0);
    rst = 1'b0;
    #1;
    check("idle_req", arb_req, 4'b0101);
    out_log.delete();
    drain(200);
    check("p1_count", out_log.size(), 4);
    if (out_log.size() == 4) for (int k = 0; k < 4; k++) check("p1_port_order", out_log[k], exp_order[k]);

    // Port 1 three-beat packet while port 3 is also waiting.
    push_pkt(1, 3);
    push_pkt(3, 2);
    drive();
    drain(200);

    // Sink stalled with a beat in the output stage.
    out_log.delete();
    push_pkt(1, 3);
    ready_pct = 0;
    drive();
    repeat (8) step();
    check("stall_out_valid", out_valid, 1);
    check("stall_no_drain", out_log.size(), 0);
    ready_pct = 100;
    drain(200);
    check("stall_all_out", out_log.size(), 3);

    // Back-to-back 8-beat packets from one port at full rate.
    push_pkt(3, 8);
    push_pkt(3, 8);
    drive();
    ovq.delete();
    repeat (40) begin
      step();
      ovq.push_back(int'(prev_ov));
    end
    s = -1;
    for (int k = 0; k < ovq.size(); k++) if (s < 0 && ovq[k] != 0) s = k;
    check("tp_started", s >= 0, 1);
    if (s >= 0) begin
      r1 = 0; g = 0; i = s;
      while (i < ovq.size() && ovq[i] != 0) begin r1++; i++; end
      while (i < ovq.size() && ovq[i] == 0) begin g++; i++; end
      check("tp_run", r1, (TB_MAX < 8) ? TB_MAX : 8);
      check("tp_gap", g, 1);
    end
    drain(200);

    // Reset after two of four beats; pending state is thrown away.
    push_pkt(0, 4);
    drive();
    a0 = acc_cnt[0];
    n  = 0;
    while (acc_cnt[0] < a0 + 2 && n < 50) begin step(); n++; end
    check("rstmid_reached", acc_cnt[0] - a0, 2);
    rst = 1'b1;
    for (int p = 0; p < 4; p++) src_head[p] = src_tail[p];
    exp_q.delete();
    in_valid = '0;
    step();
    rst = 1'b0;
    push_pkt(2, 1);
    drive();
    #1;
    check("rstmid_out_valid", out_valid, 0);
    check("rstmid_req", arb_req, 4'b0100);
    drain(200);

    // Randomized traffic on all ports with random gaps and backpressure.
    valid_pct = 70;
    ready_pct = 60;
    for (int p = 0; p < 4; p++) for (int k = 0; k < 6; k++) push_pkt(p, $urandom_range(1, 6));
    drive();
    drain(3000);

    check("err_pulses", err_seen, exp_err);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
